multi_filter_mul_arb: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares one unsigned 7-bit × 9-bit → 15-bit multiplier among `N_REQ` filter-kernel requesters inside `multi_filter`. Each requester presents operands with a valid/ready handshake. The block grants one requester per cycle, registers the operands, multiplies, and returns the 15-bit product tagged with the requester index on a single output stream with backpressure. It replaces per-kernel multiplier instances where kernels do not each need one every cycle.

---
 rtl/multi_filter_mul_arb_if.sv | 31 +++
 rtl/multi_filter_mul_arb.sv | 105 ++++++++++
 tb/tb_multi_filter_mul_arb.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_filter_mul_arb_if.sv
// Handshake bundle between the filter-kernel requesters and the shared
// multiplier: per-requester operand channels in, one tagged product out.
interface multi_filter_mul_arb_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int A_W   = 7,
  parameter int B_W   = 9,
  parameter int P_W   = 15
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ-1:0][A_W-1:0] req_a;
  logic [N_REQ-1:0][B_W-1:0] req_b;
  logic                      res_valid;
  logic                      res_ready;
  logic [P_W-1:0]            res_p;
  logic [ID_W-1:0]           res_id;
  logic                      busy;

  // requester / downstream side
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_p, res_id, busy
  );

  // shared multiplier side
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_p, res_id, busy
  );
endinterface

// File: rtl/multi_filter_mul_arb.sv
// Round-robin arbiter feeding one shared 7x9 -> 15-bit unsigned multiplier.
// Two stages: S1 holds the granted operands, S2 holds the truncated product
// tagged with the requester index. Stage occupancy (v1,v2) is the FSM state.
module multi_filter_mul_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int A_W   = 7,
  parameter int B_W   = 9,
  parameter int P_W   = 15
)(
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  multi_filter_mul_arb_if.slave bus
);
  // encoding is {v1, v2}
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    S2_ONLY = 2'b01,
    S1_ONLY = 2'b10,
    FULL    = 2'b11
  } state_t;

  state_t           state;
  logic             v1, v2;
  logic             adv1, adv2;
  logic             win_found, xfer;
  logic [ID_W-1:0]  win_id, rr;
  logic [N_REQ-1:0] grant;
  int               idx;

  logic [A_W-1:0]   a1;
  logic [B_W-1:0]   b1;
  logic [ID_W-1:0]  id1, id2;
  logic [P_W-1:0]   p2, prod;

  assign v1   = state[1];
  assign v2   = state[0];
  assign adv2 = !v2 || bus.res_ready;
  assign adv1 = !v1 || adv2;
  assign xfer = adv1 && win_found;

  // first valid requester at or after rr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr) + k) % N_REQ;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // one-hot ready to the winner only when S1 can take it
  always_comb begin
    grant = '0;
    if (xfer) grant[win_id] = 1'b1;
  end

  // ready is gated by reset so nobody handshakes while the block is held
  assign bus.req_ready = ap_rst_n ? grant : '0;

  // zero-extend both operands to P_W so the product wraps mod 2^P_W
  assign prod = P_W'(a1) * P_W'(b1);

  // occupancy FSM, operand/product registers and round-robin pointer
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= EMPTY;
      rr    <= '0;
      a1    <= '0;
      b1    <= '0;
      id1   <= '0;
      p2    <= '0;
      id2   <= '0;
    end else begin
      case (state)
        EMPTY:   state <= xfer ? S1_ONLY : EMPTY;
        S1_ONLY: state <= xfer ? FULL : S2_ONLY;
        S2_ONLY: state <= bus.res_ready ? (xfer ? S1_ONLY : EMPTY)
                                        : (xfer ? FULL    : S2_ONLY);
        FULL:    state <= bus.res_ready ? (xfer ? FULL : S2_ONLY) : FULL;
        default: state <= EMPTY;
      endcase
      if (xfer) begin
        a1  <= bus.req_a[win_id];
        b1  <= bus.req_b[win_id];
        id1 <= win_id;
        rr  <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
      end
      // S2 only loads real work; it otherwise keeps its last value
      if (adv2 && v1) begin
        p2  <= prod;
        id2 <= id1;
      end
    end
  end

  assign bus.res_valid = v2;
  assign bus.res_p     = p2;
  assign bus.res_id    = id2;
  assign bus.busy      = v1 || v2;
endmodule

// File: tb/tb_multi_filter_mul_arb.sv
// Bench for the shared multiplier arbiter: a table of single requests plus
// hand-written sequences, with a scoreboard tracking every handshake.
module tb_multi_filter_mul_arb;
  localparam int N = 4;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  multi_filter_mul_arb_if bus();

  multi_filter_mul_arb dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int passes = 0;

  typedef struct { int p; int id; } exp_t;
  exp_t sb[$];

  typedef struct { int id; int a; int b; int exp_p; } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  // scoreboard: pop on output handshake, push on input handshake
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: got p=%0d id=%0d, required no result", bus.res_p, bus.res_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_p", int'(bus.res_p), e.p);
          chk("sb_id", int'(bus.res_id), e.id);
        end
      end
      chk("ready_without_valid", int'(bus.req_ready & ~bus.req_valid), 0);
      chk("ready_onehot", int'($countones(bus.req_ready) <= 1), 1);
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back('{p: (int'(bus.req_a[i]) * int'(bus.req_b[i])) % 32768, id: i});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    ap_rst_n = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    sb.delete();
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  // present operands on one requester until granted, then drop valid
  task automatic send(input int id, input int a, input int b);
    bit got;
    got = 1'b0;
    bus.req_a[id] = 7'(a);
    bus.req_b[id] = 9'(b);
    bus.req_valid[id] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge ap_clk);
      if (bus.req_ready[id]) begin got = 1'b1; break; end
    end
    @(posedge ap_clk); #1;
    bus.req_valid[id] = 1'b0;
    if (!got) begin
      checks++;
      $display("FAIL send_timeout: got no ready on req %0d, required a grant", id);
    end
  endtask

  // let the pipe empty and confirm nothing is left outstanding
  task automatic drain();
    bit idle;
    idle = 1'b0;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge ap_clk);
      if (!bus.busy) begin idle = 1'b1; break; end
    end
    @(posedge ap_clk); #1;
    chk("drain_idle", int'(idle), 1);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic single_tbl(input vec_t v);
    bit seen;
    seen = 1'b0;
    bus.res_ready = 1'b1;
    send(v.id, v.a, v.b);
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      if (bus.res_valid) begin seen = 1'b1; break; end
    end
    chk("tbl_seen", int'(seen), 1);
    chk("tbl_p", int'(bus.res_p), v.exp_p);
    chk("tbl_id", int'(bus.res_id), v.id);
    @(posedge ap_clk); #1;
  endtask

  initial begin
    tbl[0] = '{id: 2, a: 5,   b: 9,   exp_p: 45};
    tbl[1] = '{id: 1, a: 127, b: 511, exp_p: 32129};
    tbl[2] = '{id: 0, a: 0,   b: 511, exp_p: 0};
    tbl[3] = '{id: 3, a: 1,   b: 1,   exp_p: 1};
    tbl[4] = '{id: 0, a: 127, b: 1,   exp_p: 127};
    tbl[5] = '{id: 1, a: 100, b: 300, exp_p: 30000};
    tbl[6] = '{id: 2, a: 127, b: 258, exp_p: 32766};
    tbl[7] = '{id: 3, a: 127, b: 259, exp_p: 125};

    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b0;

    // reset state, with requests already pending
    bus.req_valid = 4'hF;
    @(negedge ap_clk);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_res_p", int'(bus.res_p), 0);
    chk("rst_res_id", int'(bus.res_id), 0);
    do_reset();

    // single request from 2: same-cycle ready, two-edge latency
    bus.res_ready = 1'b1;
    bus.req_a[2] = 7'd5;
    bus.req_b[2] = 9'd9;
    bus.req_valid[2] = 1'b1;
    @(negedge ap_clk);
    chk("single_ready", int'(bus.req_ready), 4);
    @(posedge ap_clk); #1;
    bus.req_valid[2] = 1'b0;
    @(negedge ap_clk);
    chk("single_not_yet", int'(bus.res_valid), 0);
    chk("single_busy", int'(bus.busy), 1);
    @(negedge ap_clk);
    chk("single_valid", int'(bus.res_valid), 1);
    chk("single_p", int'(bus.res_p), 45);
    chk("single_id", int'(bus.res_id), 2);
    @(negedge ap_clk);
    chk("single_idle", int'(bus.busy), 0);
    @(posedge ap_clk); #1;

    foreach (tbl[i]) single_tbl(tbl[i]);
    drain();

    // all requesters continuously: 0,1,2,3,0 and back-to-back results
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = 7'(i + 1);
      bus.req_b[i] = 9'd10;
    end
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      chk("rr_grant", int'(bus.req_ready), 1 << (k % N));
      if (k >= 2) begin
        chk("rr_res_valid", int'(bus.res_valid), 1);
        chk("rr_res_id", int'(bus.res_id), k - 2);
        chk("rr_res_p", int'(bus.res_p), 10 * (k - 1));
      end
      @(posedge ap_clk); #1;
    end
    bus.req_valid = '0;
    drain();

    // backpressure: 7 and 14 queued, third request stalls
    bus.res_ready = 1'b0;
    send(1, 7, 1);
    send(1, 7, 2);
    bus.req_a[1] = 7'd7;
    bus.req_b[1] = 9'd3;
    bus.req_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      chk("bp_ready_low", int'(bus.req_ready), 0);
      chk("bp_valid", int'(bus.res_valid), 1);
      chk("bp_p_hold", int'(bus.res_p), 7);
      chk("bp_id_hold", int'(bus.res_id), 1);
      @(posedge ap_clk); #1;
    end
    bus.res_ready = 1'b1;
    @(negedge ap_clk);
    chk("bp_release_ready", int'(bus.req_ready), 2);
    @(posedge ap_clk); #1;
    bus.req_valid[1] = 1'b0;
    drain();

    // wrap and skip: rr=2 after a grant to 1, then 3 and 1 contend
    send(1, 3, 3);
    drain();
    bus.req_a[3] = 7'd2;  bus.req_b[3] = 9'd2;
    bus.req_a[1] = 7'd3;  bus.req_b[1] = 9'd5;
    bus.req_valid = 4'b1010;
    @(negedge ap_clk);
    chk("wrap_first", int'(bus.req_ready), 8);
    @(posedge ap_clk); #1;
    bus.req_a[3] = 7'd4;  bus.req_b[3] = 9'd4;
    @(negedge ap_clk);
    chk("wrap_second", int'(bus.req_ready), 2);
    @(posedge ap_clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge ap_clk);
    chk("wrap_third", int'(bus.req_ready), 8);
    @(posedge ap_clk); #1;
    bus.req_valid = '0;
    drain();

    // reset mid-operation with both stages full
    bus.res_ready = 1'b0;
    send(2, 9, 9);
    send(3, 8, 8);
    bus.req_valid = 4'hF;
    @(negedge ap_clk);
    chk("mid_full_busy", int'(bus.busy), 1);
    #2;
    ap_rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", int'(bus.res_valid), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_ready", int'(bus.req_ready), 0);
    @(posedge ap_clk);
    @(negedge ap_clk); #2;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    ap_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      chk("mid_no_stale", int'(bus.res_valid), 0);
    end
    @(posedge ap_clk); #1;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = 7'(10 + i);
      bus.req_b[i] = 9'(20 + i);
    end
    bus.req_valid = 4'hF;
    @(negedge ap_clk);
    chk("mid_first_grant", int'(bus.req_ready), 1);
    @(posedge ap_clk); #1;
    bus.req_valid = '0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
